// File: rtl/gs_div_arbiter.sv
// gs_div_arbiter: round-robin sharing of one Goldschmidt divider between NREQ requesters
module gs_div_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int GO_CYCLES = 2,
  parameter int BLANK     = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [64*NREQ-1:0] req_n,
  input  logic [64*NREQ-1:0] req_d,
  output logic              div_go,
  output logic [63:0]       div_n,
  output logic [63:0]       div_d,
  input  logic [63:0]       div_q,
  input  logic              div_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [63:0]       rsp_q,
  output logic              rsp_err,
  output logic              busy
);
  localparam int GW = $clog2(GO_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [GW-1:0]   r_go_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_go;
  logic [63:0]     r_n;
  logic [63:0]     r_d;
  logic            r_valid;
  logic [IDW-1:0]  r_id;
  logic [63:0]     r_q;
  logic            r_err;
  logic            r_busy;
  logic [IDW-1:0]  w_gid;
  logic [IDW:0]    w_idx;
  logic            w_any;
  logic [63:0]     w_n;
  logic [63:0]     w_d;
  assign w_any     = |req_valid;
  assign w_n       = req_n[{w_gid, 6'd0} +: 64];
  assign w_d       = req_d[{w_gid, 6'd0} +: 64];
  assign req_ready = (r_state == IDLE && w_any) ? NREQ'(1) << w_gid : '0;
  assign div_go    = r_go;
  assign div_n     = r_n;
  assign div_d     = r_d;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_q     = r_q;
  assign rsp_err   = r_err;
  assign busy      = r_busy;
  // pick the first valid requester at or after the round-robin pointer; scanning backwards lets the nearest one win
  always_comb begin
    w_gid = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (req_valid[w_idx[IDW-1:0]]) w_gid = w_idx[IDW-1:0];
    end
  end
  // sequencer: accept, pulse go, wait for done with blanking and timeout, hold the response until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_go_cnt   <= '0;
      r_wait_cnt <= '0;
      r_go       <= 1'b0;
      r_n        <= '0;
      r_d        <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_q        <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_n    <= w_n;
          r_d    <= w_d;
          r_id   <= w_gid;
          r_busy <= 1'b1;
          if (w_d == '0) begin
            r_q     <= '1;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= RESP;
          end else begin
            r_go_cnt <= '0;
            r_go     <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_go_cnt <= r_go_cnt + 1'b1;
          if (r_go_cnt == GW'(GO_CYCLES - 1)) begin
            r_go       <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (div_done && r_wait_cnt >= WW'(BLANK)) begin
            r_q     <= div_q;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= RESP;
          end else if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
            r_q     <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gs_div_arbiter.sv
// tb_gs_div_arbiter: directed checks of grant order, go pulse, blanking, timeout, backpressure and reset
module tb_gs_div_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [255:0] req_n = '0;
  logic [255:0] req_d = '0;
  logic         div_go;
  logic [63:0]  div_n, div_d, div_q;
  logic         div_done;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_q;
  logic         rsp_err;
  logic         busy;
  int           n_chk = 0;
  int           n_fail = 0;
  int           mode = 0;
  int           m_cnt = 8;
  logic         m_done = 1'b0;
  logic [127:0] w_quot;
  gs_div_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d), .div_go(div_go), .div_n(div_n), .div_d(div_d),
    .div_q(div_q), .div_done(div_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb begin
    w_quot = '0;
    if (div_d != '0) w_quot = ({64'b0, div_n} << 32) / {64'b0, div_d};
  end
  assign div_q    = w_quot[63:0];
  assign div_done = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : m_done;
  always @(posedge clk) begin
    if (div_go) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_cnt < 8) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 7) m_done <= 1'b1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int id, input logic [63:0] n, input logic [63:0] d, input logic [3:0] exp_rdy);
    req_n[id*64 +: 64] = n;
    req_d[id*64 +: 64] = d;
    req_valid[id] = 1'b1;
    #1 chk("ready", 64'(req_ready), 64'(exp_rdy));
    @(negedge clk);
    req_valid = '0;
  endtask
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) chk("rsp_wait_expired", 64'(rsp_valid), 64'd1);
  endtask
  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_valid", 64'(rsp_valid), 64'd0);
    chk("hs_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    int cyc;
    int gc;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic seen;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_go", 64'(div_go), 64'd0);
    chk("rst_q", rsp_q, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1, 64'h0000_0064_0000_0000, 64'h0000_0005_0000_0000, 4'b0010);
    gc = 0;
    while (div_go && gc < 10) begin
      chk("issue_busy", 64'(busy), 64'd1);
      gc++;
      @(negedge clk);
    end
    chk("go_cycles", 64'(gc), 64'd2);
    wait_rsp(cyc);
    chk("t1_id", 64'(rsp_id), 64'd1);
    chk("t1_q", rsp_q, 64'h0000_0014_0000_0000);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_div_n", div_n, 64'h0000_0064_0000_0000);
    chk("t1_div_d", div_d, 64'h0000_0005_0000_0000);
    handshake();
    issue(2, 64'h0000_0009_0000_0000, 64'd0, 4'b0100);
    chk("dz_go", 64'(div_go), 64'd0);
    wait_rsp(cyc);
    chk("dz_lat", 64'(cyc), 64'd1);
    chk("dz_q", rsp_q, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dz_err", 64'(rsp_err), 64'd1);
    chk("dz_id", 64'(rsp_id), 64'd2);
    handshake();
    req_n[63:0] = 64'h0000_0001_0000_0000;
    req_d[63:0] = 64'h0000_0001_0000_0000;
    issue(3, 64'h0000_0009_0000_0000, 64'h0000_0003_0000_0000, 4'b1000);
    req_valid = 4'b0001;
    wait_rsp(cyc);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd3);
      chk("bp_q", rsp_q, 64'h0000_0003_0000_0000);
      chk("bp_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    mode = 2;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_hs_valid", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc);
    chk("to_lat", 64'(cyc), 64'd67);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_q", rsp_q, 64'd0);
    chk("to_id", 64'(rsp_id), 64'd0);
    handshake();
    mode = 1;
    issue(1, 64'h0000_0015_0000_0000, 64'h0000_0007_0000_0000, 4'b0010);
    wait_rsp(cyc);
    chk("stale_lat", 64'(cyc), 64'd5);
    chk("stale_q", rsp_q, 64'h0000_0003_0000_0000);
    chk("stale_err", 64'(rsp_err), 64'd0);
    handshake();
    mode = 2;
    issue(2, 64'h0000_0008_0000_0000, 64'h0000_0002_0000_0000, 4'b0100);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_go", 64'(div_go), 64'd0);
    chk("mrst_n", div_n, 64'd0);
    chk("mrst_d", div_d, 64'd0);
    chk("mrst_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mode = 0;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen = seen | rsp_valid | busy;
    end
    chk("mrst_silent", 64'(seen), 64'd0);
    for (int i = 0; i < 4; i++) begin
      req_n[i*64 +: 64] = 64'(i + 1) << 32;
      req_d[i*64 +: 64] = 64'h0000_0001_0000_0000;
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      #1;
      while (req_ready == '0 && cyc < 200) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("rr_grant", 64'(req_ready), 64'd1 << exp_g[g]);
      @(negedge clk);
      #1 chk("rr_pulse", 64'(req_ready), 64'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (30) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gs_div_arbiter.md
Name: gs_div_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Goldschmidt divider (64-bit N/D in, 64-bit Q plus done out) between NREQ requesters.
- Accepts one division request at a time and latches its operands.
- Starts the divider with a held go pulse, waits for done (with stale-done blanking and a timeout), then returns the quotient tagged with the requester id.
- Sits between the divider and the client blocks that issue divisions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ.
- GO_CYCLES, 2, number of cycles div_go is held high per operation (must be >= 1).
- BLANK, 1, WAIT cycles during which div_done is ignored (masks stale done from the previous operation).
- TIMEOUT, 64, WAIT cycles before the operation is abandoned (must be > BLANK).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept; combinational.
- req_n  in  64*NREQ  dividend; requester i uses bits [64i+63:64i].
- req_d  in  64*NREQ  divisor; same packing as req_n.
- div_go  out  1  divider start; the divider restarts while this is high.
- div_n  out  64  latched dividend to the divider.
- div_d  out  64  latched divisor to the divider.
- div_q  in  64  divider quotient.
- div_done  in  1  divider done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_q  out  64  quotient.
- rsp_err  out  1  1 = divide-by-zero or timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst=0, takes effect immediately, asynchronously):
  - state=IDLE; rr_ptr=0.
  - div_go=0, div_n=0, div_d=0.
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0, busy=0.
  - go_cnt=0, wait_cnt=0.
- Reset mid-operation abandons the transaction silently: no response is produced and the requester is not re-accepted.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready = onehot(g) only in IDLE when any req_valid is high; otherwise req_ready=0.
  - A transfer occurs on valid & ready. On transfer, latch div_n=req_n[g], div_d=req_d[g], rsp_id=g.
  - If req_d[g]==0: rsp_q=64'hFFFF_FFFF_FFFF_FFFF, rsp_err=1, go to RESP. The divider is not used.
  - Otherwise go to ISSUE with go_cnt=0.
- ISSUE:
  - div_go=1 (registered, so high exactly GO_CYCLES cycles); go_cnt increments each cycle.
  - When go_cnt==GO_CYCLES-1, go to WAIT with wait_cnt=0 and div_go=0 from the next cycle.
- WAIT:
  - wait_cnt increments each cycle.
  - div_done is ignored while wait_cnt < BLANK.
  - If div_done=1 with wait_cnt >= BLANK: capture rsp_q=div_q, rsp_err=0, go to RESP.
  - Else if wait_cnt==TIMEOUT-1: rsp_q=0, rsp_err=1, go to RESP.
  - done takes priority if it arrives on the timeout cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q and rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid=0 next cycle, rr_ptr=(rsp_id+1) mod NREQ, go to IDLE.
  - No new request is accepted in the handshake cycle; earliest acceptance is the next cycle.
- div_n and div_d stay stable from acceptance until the RESP handshake.
- Requester operands need only be valid in the transfer cycle.
- Latency from transfer cycle T:
  - div_go high in cycles T+1 .. T+GO_CYCLES.
  - Divider path: rsp_valid rises 1 cycle after done is sampled.
  - Divide-by-zero path: rsp_valid rises at T+1.
- Minimum back-to-back period per requester: GO_CYCLES + BLANK + 3 cycles plus the divider latency.
- Fairness: with all requesters continuously valid, grants are issued strictly in the order rr_ptr, rr_ptr+1, ...
- Requesters with req_valid low are skipped with no idle cycle.
- Multiple simultaneous req_valid: only the one granted requester sees ready; the others keep waiting.

Test Plan:
- Single request: requester 1, N=0x0000_0064_0000_0000, D=0x0000_0005_0000_0000; divider model gives done 8 cycles after go falls.
  -> div_go high exactly 2 cycles; rsp_valid with rsp_id=1, rsp_q=0x0000_0014_0000_0000, rsp_err=0; busy low after handshake.
- Contention: all 4 requesters held valid from reset, rsp_ready=1.
  -> grant order 0,1,2,3,0; each req_ready pulse one cycle; no grant while busy.
- Divide-by-zero: requester 2, D=0.
  -> div_go never asserted; rsp_valid 1 cycle after transfer with rsp_q=all-ones, rsp_err=1, rsp_id=2.
- Stale done and timeout:
  - div_done tied high before and throughout the operation -> it is ignored during the first BLANK WAIT cycle and accepted on wait_cnt=1.
  - div_done held low -> rsp_err=1, rsp_q=0 at exactly 64 WAIT cycles.
- Backpressure: rsp_ready low for 10 cycles during RESP.
  -> rsp_valid, rsp_id, rsp_q stable all 10 cycles; no req_ready asserted; next grant 1 cycle after handshake.
- Reset mid-WAIT: rst=0 for 1 cycle.
  -> all outputs reach reset values immediately, without waiting for a clock edge; no response emitted; rr_ptr=0 so requester 0 is granted first afterwards.
